// File: rtl/nios1_nios2_qsys_mul_seq_if.sv
// Request/result handshake and multiply-cell bus for the sequential Nios II multiplier.
// master = requester plus external multiply cell, slave = nios1_nios2_qsys_mul_seq.
interface nios1_nios2_qsys_mul_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic [31:0] A_mul_src1;
  logic [31:0] A_mul_src2;
  logic [31:0] A_mul_cell_result;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result;
  logic        busy;

  modport master (
    output req_valid, req_op, req_src1, req_src2, result_ready, A_mul_cell_result,
    input  req_ready, A_mul_src1, A_mul_src2, result_valid, result, busy
  );

  modport slave (
    input  req_valid, req_op, req_src1, req_src2, result_ready, A_mul_cell_result,
    output req_ready, A_mul_src1, A_mul_src2, result_valid, result, busy
  );
endinterface

// File: rtl/nios1_nios2_qsys_mul_seq.sv
// Sequential 32x32 multiplier: MUL via one cell pass (result 2 cycles after accept); MULX high words
// via four 16x16 passes plus sign fix (6 cycles), enabled by NIOS2_MUL_SEQ_MULX_EN, otherwise MULX returns 0.
module nios1_nios2_qsys_mul_seq (
  input logic                     clk,
  input logic                     reset_n,
  nios1_nios2_qsys_mul_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PASS, DRAIN, FIX, DONE} state_t;

  state_t      state_q;
  logic [1:0]  op_q;
  logic [31:0] src1_q, src2_q, result_q;
  logic        req_ready_q, result_valid_q, busy_q;

  assign bus.req_ready    = req_ready_q;
  assign bus.result_valid = result_valid_q;
  assign bus.busy         = busy_q;
  assign bus.result       = result_q;
  assign bus.A_mul_src1   = src1_q;
  assign bus.A_mul_src2   = src2_q;

`ifdef NIOS2_MUL_SEQ_MULX_EN
  logic [31:0] a_q, b_q;
  logic [1:0]  pass_q, pass_nxt;
  logic [63:0] acc_q, acc_d;
  logic [31:0] high_d;

  assign pass_nxt = pass_q + 2'd1;

  // pass_q names the product currently on the cell output: {al,bl},{ah,bl},{al,bh},{ah,bh}
  always_comb begin
    acc_d = acc_q;
    case (pass_q)
      2'd0:    acc_d = acc_q + {32'd0, bus.A_mul_cell_result};
      2'd1,
      2'd2:    acc_d = acc_q + ({32'd0, bus.A_mul_cell_result} << 16);
      default: acc_d = acc_q + {bus.A_mul_cell_result, 32'd0};
    endcase
    high_d = acc_q[63:32];
    if (op_q[1] && a_q[31])
      high_d = high_d - b_q;
    if ((op_q == 2'b11) && b_q[31])
      high_d = high_d - a_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      op_q           <= 2'b00;
      src1_q         <= 32'd0;
      src2_q         <= 32'd0;
      result_q       <= 32'd0;
      req_ready_q    <= 1'b1;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
`ifdef NIOS2_MUL_SEQ_MULX_EN
      a_q            <= 32'd0;
      b_q            <= 32'd0;
      pass_q         <= 2'd0;
      acc_q          <= 64'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            op_q        <= bus.req_op;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
`ifdef NIOS2_MUL_SEQ_MULX_EN
            a_q    <= bus.req_src1;
            b_q    <= bus.req_src2;
            pass_q <= 2'd0;
            acc_q  <= 64'd0;
            if (bus.req_op != 2'b00) begin
              src1_q  <= {16'd0, bus.req_src1[15:0]};
              src2_q  <= {16'd0, bus.req_src2[15:0]};
              state_q <= PASS;
            end else begin
              src1_q  <= bus.req_src1;
              src2_q  <= bus.req_src2;
              state_q <= DRAIN;
            end
`else
            src1_q  <= bus.req_src1;
            src2_q  <= bus.req_src2;
            state_q <= DRAIN;
`endif
          end
        end
`ifdef NIOS2_MUL_SEQ_MULX_EN
        PASS: begin
          acc_q  <= acc_d;
          pass_q <= pass_nxt;
          src1_q <= {16'd0, pass_nxt[0] ? a_q[31:16] : a_q[15:0]};
          src2_q <= {16'd0, pass_nxt[1] ? b_q[31:16] : b_q[15:0]};
          if (pass_q == 2'd2)
            state_q <= DRAIN;
        end
        DRAIN: begin
          if (op_q == 2'b00) begin
            result_q       <= bus.A_mul_cell_result;
            result_valid_q <= 1'b1;
            state_q        <= DONE;
          end else begin
            acc_q   <= acc_d;
            state_q <= FIX;
          end
        end
        FIX: begin
          result_q       <= high_d;
          result_valid_q <= 1'b1;
          state_q        <= DONE;
        end
`else
        DRAIN: begin
          result_q       <= (op_q == 2'b00) ? bus.A_mul_cell_result : 32'd0;
          result_valid_q <= 1'b1;
          state_q        <= DONE;
        end
`endif
        DONE: begin
          if (bus.result_ready) begin
            result_valid_q <= 1'b0;
            req_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: begin
          result_valid_q <= 1'b0;
          req_ready_q    <= 1'b1;
          busy_q         <= 1'b0;
          state_q        <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nios1_nios2_qsys_mul_seq.sv
// Directed bench for nios1_nios2_qsys_mul_seq; expectations follow NIOS2_MUL_SEQ_MULX_EN when defined.
module tb_nios1_nios2_qsys_mul_seq;
`ifdef NIOS2_MUL_SEQ_MULX_EN
  localparam bit MULX_ON = 1'b1;
`else
  localparam bit MULX_ON = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  logic [31:0] trace1 [0:20];
  logic [31:0] trace2 [0:20];

  nios1_nios2_qsys_mul_seq_if bus ();

  nios1_nios2_qsys_mul_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // External multiply cell: low word of the registered operands
  assign bus.A_mul_cell_result = bus.A_mul_src1 * bus.A_mul_src2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       nm;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Issues one request, measures latency (accept cycle = 0), checks result and the handshake back to IDLE
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat, input string nm);
    int lat;
    bit got;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_src1  = a;
    bus.req_src2  = b;
    chk({nm, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      bus.req_valid = 1'b0;
      trace1[lat] = bus.A_mul_src1;
      trace2[lat] = bus.A_mul_src2;
      if (bus.result_valid) got = 1'b1;
    end
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_result"}, bus.result, exp);
    @(negedge clk);
    bus.result_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.result_ready = 1'b0;
    chk({nm, "_idle_ready"}, {31'd0, bus.req_ready}, 32'd1);
    chk({nm, "_idle_valid"}, {31'd0, bus.result_valid}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    checks   = 0;
    failures = 0;

    vecs[0]  = '{2'b00, 32'd3,         32'd5,         32'h0000000F, 2, "mul_3x5"};
    vecs[1]  = '{2'b00, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001, 2, "mul_ffxff"};
    vecs[2]  = '{2'b00, 32'h00010000,  32'h00010000,  32'h00000000, 2, "mul_wrap"};
    vecs[3]  = '{2'b00, 32'h12345678,  32'h00000010,  32'h23456780, 2, "mul_shift"};
    vecs[4]  = '{2'b01, 32'hFFFFFFFF,  32'hFFFFFFFF,  MULX_ON ? 32'hFFFFFFFE : 32'h0, MULX_ON ? 6 : 2, "mulxuu_ff"};
    vecs[5]  = '{2'b11, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000, MULX_ON ? 6 : 2, "mulxss_m1"};
    vecs[6]  = '{2'b10, 32'hFFFFFFFF,  32'd2,         MULX_ON ? 32'hFFFFFFFF : 32'h0, MULX_ON ? 6 : 2, "mulxsu_m1x2"};
    vecs[7]  = '{2'b11, 32'h80000000,  32'h80000000,  MULX_ON ? 32'h40000000 : 32'h0, MULX_ON ? 6 : 2, "mulxss_min"};
    vecs[8]  = '{2'b01, 32'h00010000,  32'h00010000,  MULX_ON ? 32'h00000001 : 32'h0, MULX_ON ? 6 : 2, "mulxuu_2p32"};
    vecs[9]  = '{2'b10, 32'd2,         32'hFFFFFFFF,  MULX_ON ? 32'h00000001 : 32'h0, MULX_ON ? 6 : 2, "mulxsu_2xff"};
    vecs[10] = '{2'b11, 32'd2,         32'hFFFFFFFF,  MULX_ON ? 32'hFFFFFFFF : 32'h0, MULX_ON ? 6 : 2, "mulxss_2xm1"};

    reset_n          = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_op       = 2'b00;
    bus.req_src1     = 32'd0;
    bus.req_src2     = 32'd0;
    bus.result_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_result_valid", {31'd0, bus.result_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_src1", bus.A_mul_src1, 32'd0);
    chk("rst_src2", bus.A_mul_src2, 32'd0);
    reset_n = 1'b1;

    // result_ready while nothing is pending must do nothing
    bus.result_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("idle_rr_valid", {31'd0, bus.result_valid}, 32'd0);
      chk("idle_rr_busy", {31'd0, bus.busy}, 32'd0);
    end
    bus.result_ready = 1'b0;

    for (int i = 0; i < 11; i++)
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].nm);

    // Operand sequence presented to the cell for MULXUU all-ones
    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, MULX_ON ? 32'hFFFFFFFE : 32'h0, MULX_ON ? 6 : 2, "trace_op");
`ifdef NIOS2_MUL_SEQ_MULX_EN
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("trace_src1_c%0d", k), trace1[k], 32'h0000FFFF);
      chk($sformatf("trace_src2_c%0d", k), trace2[k], 32'h0000FFFF);
    end
`else
    for (int k = 1; k <= 2; k++) begin
      chk($sformatf("trace_src1_c%0d", k), trace1[k], 32'hFFFFFFFF);
      chk($sformatf("trace_src2_c%0d", k), trace2[k], 32'hFFFFFFFF);
    end
`endif

    // Backpressure: hold result for 10 cycles, then release and issue a fresh request
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b00;
    bus.req_src1  = 32'd7;
    bus.req_src2  = 32'd9;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("bp_valid_%0d", k), {31'd0, bus.result_valid}, 32'd1);
      chk($sformatf("bp_result_%0d", k), bus.result, 32'h0000003F);
      chk($sformatf("bp_req_ready_%0d", k), {31'd0, bus.req_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    bus.result_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.result_ready = 1'b0;
    chk("bp_release_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("bp_release_valid", {31'd0, bus.result_valid}, 32'd0);
    do_op(2'b00, 32'd6, 32'd7, 32'd42, 2, "bp_next");

    // Reset in the middle of a MULX sequence
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b01;
    bus.req_src1  = 32'hFFFFFFFF;
    bus.req_src2  = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("abort_busy", {31'd0, bus.busy}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("abort_valid", {31'd0, bus.result_valid}, 32'd0);
    chk("abort_busy_clr", {31'd0, bus.busy}, 32'd0);
    chk("abort_result", bus.result, 32'd0);
    chk("abort_src1", bus.A_mul_src1, 32'd0);
    chk("abort_src2", bus.A_mul_src2, 32'd0);
    reset_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.result_valid) seen++;
    end
    chk("abort_no_result", seen, 32'd0);
    do_op(2'b00, 32'd2, 32'd2, 32'd4, 2, "after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
